// File: rtl/aes_inv_round_engine.sv
// aes_inv_round_engine: iterative AES inverse cipher, byte-serial InvSubBytes via an external S-box port.
// Optional abort input is compiled in when AES_INV_ABORT_EN is defined.
module aes_inv_round_engine #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef AES_INV_ABORT_EN
   input  logic         abort,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_data,
   output logic [7:0]   sbox_in,
   input  logic [7:0]   sbox_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);
   typedef enum logic [2:0] {IDLE, ISR, ISB, ARK, DONE} fsm_t;
   localparam logic [3:0] NR_L = 4'(NR);
   fsm_t         fsm, fsm_nxt;
   logic [127:0] state, state_nxt, t;
   logic [3:0]   round_cnt, rc_nxt, byte_cnt, bc_nxt;
   logic         kill;

   // GF(2^8) multiply by a 4-bit constant, built from repeated xtime
   function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] p, x;
      p = '0;
      x = b;
      for (int i = 0; i < 4; i++) begin
         p = k[i] ? p ^ x : p;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // row r rotates right by r: out[r][c] = in[r][(c-r) mod 4]
   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   // each column multiplied by the circulant {0e,0b,0d,09}
   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = gm(a[r], 4'he) ^ gm(a[(r+1)%4], 4'hb) ^
                                    gm(a[(r+2)%4], 4'hd) ^ gm(a[(r+3)%4], 4'h9);
      end
      return o;
   endfunction

`ifdef AES_INV_ABORT_EN
   assign kill = abort && (fsm != IDLE);
`else
   assign kill = 1'b0;
`endif

   assign t         = state ^ rk_data;
   assign in_ready  = (fsm == IDLE);
   assign out_valid = (fsm == DONE);
   assign out_data  = (fsm == DONE) ? state : '0;
   assign rk_idx    = (fsm == IDLE) ? NR_L : round_cnt;
   assign sbox_in   = (fsm == ISB) ? state[{~byte_cnt, 3'b000} +: 8] : 8'h00;

   // round sequencing: whitening key, then NR x (InvShiftRows, 16 S-box lookups, AddRoundKey/InvMixColumns)
   always_comb begin
      fsm_nxt   = fsm;
      state_nxt = state;
      rc_nxt    = round_cnt;
      bc_nxt    = byte_cnt;
      case (fsm)
         IDLE: if (in_valid) begin
            state_nxt = in_data ^ rk_data;
            rc_nxt    = NR_L - 4'd1;
            fsm_nxt   = ISR;
         end
         ISR: begin
            state_nxt = inv_shift(state);
            bc_nxt    = '0;
            fsm_nxt   = ISB;
         end
         ISB: begin
            state_nxt[{~byte_cnt, 3'b000} +: 8] = sbox_out;
            bc_nxt  = byte_cnt + 4'd1;
            fsm_nxt = (byte_cnt == 4'd15) ? ARK : ISB;
         end
         ARK: begin
            state_nxt = (round_cnt != '0) ? inv_mix(t) : t;
            rc_nxt    = (round_cnt != '0) ? round_cnt - 4'd1 : round_cnt;
            fsm_nxt   = (round_cnt != '0) ? ISR : DONE;
         end
         DONE: fsm_nxt = out_ready ? IDLE : DONE;
         default: fsm_nxt = IDLE;
      endcase
      if (kill) begin
         fsm_nxt   = IDLE;
         state_nxt = '0;
         bc_nxt    = '0;
         rc_nxt    = NR_L;
      end
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fsm       <= IDLE;
         state     <= '0;
         round_cnt <= NR_L;
         byte_cnt  <= '0;
      end else begin
         fsm       <= fsm_nxt;
         state     <= state_nxt;
         round_cnt <= rc_nxt;
         byte_cnt  <= bc_nxt;
      end
endmodule

// File: tb/tb_aes_inv_round_engine.sv
// tb_aes_inv_round_engine: vector table plus scoreboard bench for the AES inverse round engine.
module tb_aes_inv_round_engine;
   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic         in_ready, out_valid;
   logic [127:0] in_data = '0, rk_data, out_data;
   logic [3:0]   rk_idx;
   logic [7:0]   sbox_in, sbox_out;
`ifdef AES_INV_ABORT_EN
   logic         abort = 1'b0;
`endif
   logic [7:0]   fsb [256];
   logic [7:0]   isb [256];
   logic [127:0] rks [16];
   logic [127:0] exp_q [$];
   logic [127:0] cur_exp = '0;
   bit           cur_push = 0, chk_rk = 0, prev_ov = 0;
   int           n_chk = 0, n_fail = 0, ncyc = 0, hs_cyc = -1000, last_ohs = -1000;
   vec_t         vecs [3];

   aes_inv_round_engine #(.NR(10)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_ABORT_EN
      .abort(abort),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rk_idx(rk_idx), .rk_data(rk_data), .sbox_in(sbox_in), .sbox_out(sbox_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;
   assign rk_data  = rks[rk_idx];
   assign sbox_out = isb[sbox_in];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         fsb[a] = s;
         isb[s] = 8'(a);
      end
   endtask

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tw;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tw = w[i-1];
         if (i % 4 == 0) begin
            tw = {fsb[tw[23:16]], fsb[tw[15:8]], fsb[tw[7:0]], fsb[tw[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tw;
      end
      for (int r = 0; r < 16; r++) rks[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   // monitor: input-handshake push, output-handshake pop, latency and key-index timing
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            hs_cyc = ncyc;
            if (cur_push) exp_q.push_back(cur_exp);
         end
         if (chk_rk && ncyc - hs_cyc <= 180 && (ncyc - hs_cyc) % 18 == 0)
            check("rk_idx_seq", 128'(rk_idx), 128'(10 - (ncyc - hs_cyc) / 18));
         if (out_valid && !prev_ov) check("latency", 128'(ncyc - hs_cyc), 128'(181));
         if (out_valid && out_ready) begin
            last_ohs = ncyc;
            if (exp_q.size() == 0) check("unexpected_output", 128'(1), 128'(0));
            else check("out_data", out_data, exp_q.pop_front());
         end
      end
      prev_ov = out_valid;
   end

   task automatic send(input vec_t v, input bit push);
      bit ok;
      ok = 0;
      load_key(v.key);
      cur_exp  = v.pt;
      cur_push = push;
      in_data  = v.ct;
      in_valid = 1'b1;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("in_handshake_timeout", 128'(ok), 128'(1));
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(posedge clk);
         #1 ok = (exp_q.size() == 0) && in_ready;
      end
      check("drain_timeout", 128'(ok), 128'(1));
   endtask

   task automatic wait_out_valid();
      bit ok;
      ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      check("out_valid_timeout", 128'(ok), 128'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] held;
      int got;
      bit seen;
      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
      build_sbox();
      load_key('0);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", out_data, '0);
      check("rst_sbox_in", 128'(sbox_in), 128'(0));
      check("rst_rk_idx", 128'(rk_idx), 128'(10));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int v = 0; v < 3; v++) begin
         chk_rk = (v == 1);
         send(vecs[v], 1);
         drain();
         chk_rk = 0;
      end

      out_ready = 1'b0;
      send(vecs[0], 1);
      wait_out_valid();
      held = out_data;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_out_data", out_data, held);
         check("bp_in_ready", 128'(in_ready), 128'(0));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 check("bp_in_ready_after", 128'(in_ready), 128'(1));
      check("bp_out_valid_after", 128'(out_valid), 128'(0));
      drain();

      load_key(vecs[0].key);
      cur_exp  = vecs[0].pt;
      cur_push = 1;
      in_data  = vecs[0].ct;
      in_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 1000 && got < 2; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got++;
            if (got == 2) check("b2b_gap", 128'(ncyc - last_ohs), 128'(1));
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("b2b_accepts", 128'(got), 128'(2));
      drain();

      send(vecs[0], 0);
      repeat (49) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("mid_rst_out_valid", 128'(out_valid), 128'(0));
      check("mid_rst_sbox_in", 128'(sbox_in), 128'(0));
      check("mid_rst_in_ready", 128'(in_ready), 128'(1));
      check("mid_rst_out_data", out_data, '0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      send(vecs[0], 1);
      drain();

`ifdef AES_INV_ABORT_EN
      send(vecs[0], 0);
      repeat (99) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_in_ready", 128'(in_ready), 128'(1));
      check("abort_out_valid", 128'(out_valid), 128'(0));
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         seen |= out_valid;
      end
      check("abort_no_output", 128'(seen), 128'(0));
      abort = 1'b1;
      send(vecs[2], 1);
      abort = 1'b0;
      drain();
      out_ready = 1'b0;
      send(vecs[0], 0);
      wait_out_valid();
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_done_out_valid", 128'(out_valid), 128'(0));
      check("abort_done_in_ready", 128'(in_ready), 128'(1));
      out_ready = 1'b1;
      send(vecs[0], 1);
      drain();
`endif

      repeat (5) @(posedge clk);
      check("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
